sdc_data_tx: RTL and testbench

- SD-bus write-data engine in 4-bit mode, on the sd_clk domain.
- Consumes the 32-bit word stream that the SD DMA's TX FIFO produces (valid/ready) and serializes it onto DAT[3:0] as SD data blocks: start bit, payload, per-line CRC16, end bit.
- After each block it receives the card's CRC status token and waits out busy.
- It is the direct downstream consumer of the DMA stage's sd_tx_data/sd_tx_valid/sd_tx_ready stream.

---
 rtl/sdc_data_tx.sv | 245 ++++++++++++++++++++++++
 tb/tb_sdc_data_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_data_tx.sv
// sdc_data_tx: SD-bus 4-bit write-data engine (sd_clk domain).
// Serializes a 32-bit valid/ready word stream into framed SD data blocks
// (start nibble, payload, per-line CRC16, end nibble), then collects the
// card's CRC-status token and waits out DAT0 busy before the next block.
module sdc_data_tx #(
  parameter int unsigned STATUS_TIMEOUT = 1024,
  parameter int unsigned BUSY_TIMEOUT   = 65535
) (
  input  logic        sd_clk,
  input  logic        sd_rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        start,
  input  logic [11:0] blk_size,
  input  logic [15:0] blk_cnt,
  output logic [3:0]  sd_dat_out,
  output logic        sd_dat_oe,
  input  logic [3:0]  sd_dat_in,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_CRC, S_END,
    S_TURN, S_STATUS, S_BUSY, S_FIN, S_ABORT
  } state_e;

  localparam logic [16:0] STATUS_LIM = 17'(STATUS_TIMEOUT - 1);
  localparam logic [16:0] BUSY_LIM   = 17'(BUSY_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       hold_q, hold_d;       // one-word holding register
  logic              hold_full_q, hold_full_d;
  logic [31:0]       sh_q, sh_d;           // nibble shifter, next nibble in [31:28]
  logic [11:0]       size_q, size_d;
  logic [15:0]       rem_q, rem_d;         // blocks still to send
  logic [12:0]       cnt_q, cnt_d;         // nibble / CRC / turn / token phase counter
  logic [16:0]       tmr_q, tmr_d;         // status and busy timeout timer
  logic [2:0]        tok_q, tok_d;
  logic [3:0][15:0]  crc_q, crc_d;         // one CRC16 per DAT line
  logic [2:0]        err_q, err_d;

  logic        take;
  logic        dat0;
  logic [12:0] nib_last;
  logic        unused_dat;

  assign dat0       = sd_dat_in[0];
  assign unused_dat = ^sd_dat_in[3:1];
  assign nib_last   = {size_q, 1'b0} - 13'd1;

  assign busy    = !(state_q inside {S_IDLE, S_FIN, S_ABORT});
  assign done    = state_q inside {S_FIN, S_ABORT};
  assign s_ready = busy & ~hold_full_q;
  assign take    = s_valid & s_ready;
  assign err     = err_q;

  // CRC16-CCITT (x^16+x^12+x^5+1) one-bit serial update.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
  endfunction

  // Byte0 goes out first, high nibble first: put byte0 at the top of the shifter.
  function automatic logic [31:0] byte_order(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the async reset releases DAT the instant rst_n falls.
  always_ff @(posedge sd_clk or negedge sd_rst_n) begin
    if (!sd_rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      size_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      tok_q       <= '0;
      crc_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      size_q      <= size_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      tok_q       <= tok_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    size_d      = size_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    tok_d       = tok_q;
    crc_d       = crc_q;
    err_d       = err_q;

    if (take) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: if (start) begin
        size_d      = blk_size;
        rem_d       = (blk_cnt == 16'd0) ? 16'd1 : blk_cnt;
        err_d       = '0;
        hold_full_d = 1'b0;  // a word stranded by an earlier abort is stale
        state_d     = S_FETCH;
      end
      S_FETCH: if (hold_full_q) begin
        sh_d        = byte_order(hold_q);
        hold_full_d = 1'b0;
        state_d     = S_START;
      end
      S_START: begin
        crc_d   = '0;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        for (int i = 0; i < 4; i++) crc_d[i] = crc16_step(crc_q[i], sh_q[28+i]);
        if (cnt_q == nib_last) begin
          cnt_d   = '0;
          state_d = S_CRC;
        end else if (cnt_q[2:0] == 3'd7) begin
          if (hold_full_q) begin
            sh_d        = byte_order(hold_q);
            hold_full_d = 1'b0;
            cnt_d       = cnt_q + 13'd1;
          end else begin
            err_d[0] = 1'b1;
            state_d  = S_ABORT;
          end
        end else begin
          sh_d  = {sh_q[27:0], 4'h0};
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_CRC: begin
        for (int i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
        if (cnt_q == 13'd15) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_END: begin
        cnt_d   = '0;
        state_d = S_TURN;
      end
      S_TURN: if (cnt_q == 13'd1) begin
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = S_STATUS;
      end else begin
        cnt_d = cnt_q + 13'd1;
      end
      S_STATUS: begin
        if (cnt_q == 13'd0) begin
          // Waiting for the token start bit.
          if (!dat0) begin
            cnt_d = 13'd1;
          end else if (tmr_q == STATUS_LIM) begin
            err_d[2] = 1'b1;
            state_d  = S_ABORT;
          end else begin
            tmr_d = tmr_q + 17'd1;
          end
        end else if (cnt_q != 13'd4) begin
          tok_d = {tok_q[1:0], dat0};
          cnt_d = cnt_q + 13'd1;
        end else begin
          // Token end-bit cycle: judge the three status bits.
          tmr_d = '0;
          if (tok_q == 3'b010) begin
            state_d = S_BUSY;
          end else begin
            err_d[1] = 1'b1;
            state_d  = S_ABORT;
          end
        end
      end
      S_BUSY: begin
        if (dat0) begin
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_FIN : S_FETCH;
        end else if (tmr_q == BUSY_LIM) begin
          err_d[2] = 1'b1;
          state_d  = S_ABORT;
        end else begin
          tmr_d = tmr_q + 17'd1;
        end
      end
      S_FIN, S_ABORT: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // DAT line drive decoded from the current state.
  always_comb begin
    sd_dat_out = 4'hF;
    sd_dat_oe  = 1'b0;
    unique case (state_q)
      S_START: begin
        sd_dat_out = 4'h0;
        sd_dat_oe  = 1'b1;
      end
      S_DATA: begin
        sd_dat_out = sh_q[31:28];
        sd_dat_oe  = 1'b1;
      end
      S_CRC: begin
        for (int i = 0; i < 4; i++) sd_dat_out[i] = crc_q[i][15];
        sd_dat_oe = 1'b1;
      end
      S_END: sd_dat_oe = 1'b1;
      default: begin
        sd_dat_out = 4'hF;
        sd_dat_oe  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdc_data_tx.sv
// tb_sdc_data_tx: table-driven bench for sdc_data_tx with a word source,
// a DAT-line capture monitor, a simple card model and a CRC16 reference.
module tb_sdc_data_tx;

  localparam int STATUS_TIMEOUT = 1024;
  localparam int BUSY_TIMEOUT   = 65535;

  logic        sd_clk = 1'b0;
  logic        sd_rst_n = 1'b1;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        start = 1'b0;
  logic [11:0] blk_size = 12'd4;
  logic [15:0] blk_cnt = 16'd1;
  logic [3:0]  sd_dat_out;
  logic        sd_dat_oe;
  logic [3:0]  sd_dat_in;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  sdc_data_tx #(.STATUS_TIMEOUT(STATUS_TIMEOUT), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .sd_clk(sd_clk), .sd_rst_n(sd_rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .start(start), .blk_size(blk_size), .blk_cnt(blk_cnt),
    .sd_dat_out(sd_dat_out), .sd_dat_oe(sd_dat_oe), .sd_dat_in(sd_dat_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sd_clk = ~sd_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- word source ----------------
  logic [31:0] words[$];
  int          word_idx = 0;
  int          hs_cnt   = 0;

  initial begin
    bit hs;
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge sd_clk);
      hs = s_valid && s_ready;
      @(posedge sd_clk);
      #1;
      if (hs) begin
        hs_cnt++;
        word_idx++;
      end
      if (word_idx < words.size()) begin
        s_valid = 1'b1;
        s_data  = words[word_idx];
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
      end
    end
  end

  // ---------------- DAT capture monitor ----------------
  logic [3:0] cap[$];
  int   done_cnt = 0;
  int   fall_cyc = 0;
  int   done_cyc = 0;
  int   cyc      = 0;
  logic prev_oe  = 1'b0;
  event oe_fell;

  initial begin
    forever begin
      @(negedge sd_clk);
      cyc++;
      if (sd_dat_oe) cap.push_back(sd_dat_out);
      if (prev_oe && !sd_dat_oe) begin
        fall_cyc = cyc;
        -> oe_fell;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_oe = sd_dat_oe;
    end
  end

  // ---------------- card model ----------------
  int         card_mode = 0;   // 0: silent, 1: token + busy
  logic [2:0] card_tok  = 3'b010;
  int         card_busy = 4;

  initial begin
    sd_dat_in = 4'hF;
    forever begin
      @(oe_fell);
      if (card_mode != 0) begin
        repeat (2) @(negedge sd_clk);
        sd_dat_in = 4'hE;                         // token start bit
        @(negedge sd_clk);
        for (int b = 2; b >= 0; b--) begin
          sd_dat_in = {3'b111, card_tok[b]};
          @(negedge sd_clk);
        end
        sd_dat_in = 4'hF;                         // token end bit
        @(negedge sd_clk);
        for (int b = 0; b < card_busy; b++) begin
          sd_dat_in = 4'hE;                       // busy
          @(negedge sd_clk);
        end
        sd_dat_in = 4'hF;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] seed, input int j);
    if (seed == 32'h0) return 32'h0;
    return seed + 32'(j) * 32'h01020304;
  endfunction

  typedef struct {
    int         size;
    int         cnt;
    int         nwords;
    logic [31:0] seed;
    int         card;
    logic [2:0] tok;
    int         exp_len;
    logic [2:0] exp_err;
    int         exp_hs;
    bit         dbl_start;
    bit         chk_to;
  } tcase_t;

  task automatic prep(input tcase_t tc);
    @(negedge sd_clk);
    #1;
    words.delete();
    for (int j = 0; j < tc.nwords; j++) words.push_back(word_of(tc.seed, j));
    word_idx  = 0;
    hs_cnt    = 0;
    cap.delete();
    done_cnt  = 0;
    card_mode = tc.card;
    card_tok  = tc.tok;
    card_busy = 4;
    blk_size  = 12'(tc.size);
    blk_cnt   = 16'(tc.cnt);
  endtask

  task automatic pulse_start();
    @(posedge sd_clk);
    #1 start = 1'b1;
    @(posedge sd_clk);
    #1 start = 1'b0;
  endtask

  task automatic run_case(input tcase_t tc, input int id);
    logic [3:0]  exp_q[$];
    logic [15:0] crc[4];
    logic [31:0] wd;
    logic [7:0]  by;
    logic [3:0]  nib;
    int wpb, eff, budget, mism, n, lat;

    prep(tc);
    pulse_start();
    @(negedge sd_clk);
    check($sformatf("c%0d_busy_after_start", id), 32'(busy), 32'd1);

    if (tc.dbl_start) begin
      repeat (20) @(negedge sd_clk);
      blk_size = 12'd4;
      blk_cnt  = 16'd1;
      pulse_start();
    end

    eff    = (tc.cnt == 0) ? 1 : tc.cnt;
    budget = eff * (2 * tc.size + 80) + 2 * STATUS_TIMEOUT;
    for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge sd_clk);
    repeat (10) @(negedge sd_clk);

    check($sformatf("c%0d_done_count", id), 32'(done_cnt), 32'd1);
    check($sformatf("c%0d_err", id), 32'(err), 32'(tc.exp_err));
    check($sformatf("c%0d_busy_idle", id), 32'(busy), 32'd0);
    check($sformatf("c%0d_handshakes", id), 32'(hs_cnt), 32'(tc.exp_hs));
    check($sformatf("c%0d_stream_len", id), 32'(cap.size()), 32'(tc.exp_len));

    // Expected DAT stream for every block the transfer would send.
    wpb = tc.size / 4;
    for (int b = 0; b < eff; b++) begin
      exp_q.push_back(4'h0);
      for (int i = 0; i < 4; i++) crc[i] = 16'h0;
      for (int w = 0; w < wpb; w++) begin
        wd = word_of(tc.seed, b * wpb + w);
        for (int k = 0; k < 8; k++) begin
          by  = 8'(wd >> (8 * (k / 2)));
          nib = (k % 2 == 0) ? by[7:4] : by[3:0];
          exp_q.push_back(nib);
          for (int i = 0; i < 4; i++) crc[i] = ref_crc(crc[i], nib[i]);
        end
      end
      for (int t = 15; t >= 0; t--) begin
        for (int i = 0; i < 4; i++) nib[i] = crc[i][t];
        exp_q.push_back(nib);
      end
      exp_q.push_back(4'hF);
    end
    n    = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    mism = 0;
    for (int k = 0; k < n; k++) if (cap[k] !== exp_q[k]) mism++;
    check($sformatf("c%0d_stream_mismatches", id), 32'(mism), 32'd0);

    if (tc.chk_to) begin
      lat = done_cyc - fall_cyc;
      check($sformatf("c%0d_timeout_latency_in_range", id),
            32'(lat >= STATUS_TIMEOUT && lat <= STATUS_TIMEOUT + 8), 32'd1);
    end

    // Recover if the transfer never finished.
    if (busy) begin
      sd_rst_n = 1'b0;
      #3 sd_rst_n = 1'b1;
    end
  endtask

  tcase_t     tbl[8];
  tcase_t     clean;
  logic [3:0] a1_exp[8];

  initial begin
    //            size cnt nwords seed          card tok     len   err     hs  dbl to
    tbl[0] = '{ 512,  1,  128, 32'h00000000, 1, 3'b010, 1042, 3'b000, 128, 0, 0};
    tbl[1] = '{   4,  1,    1, 32'hA1B2C3D4, 1, 3'b010,   26, 3'b000,   1, 0, 0};
    tbl[2] = '{   8,  3,    6, 32'h0F1E2D3C, 1, 3'b010,  102, 3'b000,   6, 1, 0};
    tbl[3] = '{   8,  2,    1, 32'h5A5A1234, 0, 3'b010,    9, 3'b001,   1, 0, 0};
    tbl[4] = '{   8,  2,    4, 32'h31415926, 1, 3'b101,   34, 3'b010,   3, 0, 0};
    tbl[5] = '{   4,  1,    1, 32'hCAFEF00D, 0, 3'b010,   26, 3'b100,   1, 0, 1};
    tbl[6] = '{   4,  0,    1, 32'h13579BDF, 1, 3'b010,   26, 3'b000,   1, 0, 0};
    tbl[7] = '{2048,  1,  512, 32'h89ABCDEF, 1, 3'b010, 4114, 3'b000, 512, 0, 0};
    clean  = '{   4,  1,    1, 32'h600DCAFE, 1, 3'b010,   26, 3'b000,   1, 0, 0};
    a1_exp = '{4'hD, 4'h4, 4'hC, 4'h3, 4'hB, 4'h2, 4'hA, 4'h1};

    // Reset state.
    #1 sd_rst_n = 1'b0;
    #2;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_dat_out", 32'(sd_dat_out), 32'hF);
    check("rst_dat_oe", 32'(sd_dat_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge sd_clk);
    sd_rst_n = 1'b1;
    repeat (2) @(negedge sd_clk);

    for (int i = 0; i < 8; i++) begin
      run_case(tbl[i], i);
      if (i == 1) begin
        for (int k = 0; k < 8; k++) begin
          if (k + 1 < cap.size())
            check($sformatf("a1b2_nibble%0d", k), 32'(cap[k+1]), 32'(a1_exp[k]));
          else
            check($sformatf("a1b2_nibble%0d_present", k), 32'd0, 32'd1);
        end
      end
    end

    // Reset during DATA releases DAT immediately, without a done pulse.
    prep('{16, 1, 4, 32'h7777AAAA, 0, 3'b010, 0, 3'b000, 0, 0, 0});
    pulse_start();
    for (int k = 0; k < 200 && cap.size() < 12; k++) @(negedge sd_clk);
    check("mid_reset_in_data", 32'(sd_dat_oe), 32'd1);
    #2 sd_rst_n = 1'b0;
    #1;
    check("mid_reset_oe", 32'(sd_dat_oe), 32'd0);
    check("mid_reset_dat", 32'(sd_dat_out), 32'hF);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_s_ready", 32'(s_ready), 32'd0);
    check("mid_reset_err", 32'(err), 32'd0);
    repeat (3) @(negedge sd_clk);
    check("mid_reset_no_done", 32'(done_cnt), 32'd0);
    #1 sd_rst_n = 1'b1;
    repeat (2) @(negedge sd_clk);
    run_case(clean, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
